// File: rtl/kw_fetch_sequencer_if.sv
// kw_fetch_sequencer_if
//   Bundles the ROM-side and PE-side signals of the kernel-weight fetch
//   sequencer.
//   master : sequencer side. Drives F, rom_addr, rom_en, kw_out, kw_f,
//            kw_valid and kw_last. Receives kw_in and kw_ready.
//   slave  : mux/ROM plus PE-array side. Drives kw_in and kw_ready.
//   Parameters: WORD_W is the weight word width, ADDR_W is the ROM address width.
interface kw_fetch_sequencer_if #(
    parameter int unsigned WORD_W = 384,
    parameter int unsigned ADDR_W = 6
);
    logic [2:0]        F;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [WORD_W-1:0] kw_in;
    logic [WORD_W-1:0] kw_out;
    logic [2:0]        kw_f;
    logic              kw_valid;
    logic              kw_ready;
    logic              kw_last;

    modport master (
        output F, rom_addr, rom_en, kw_out, kw_f, kw_valid, kw_last,
        input  kw_in, kw_ready
    );

    modport slave (
        input  F, rom_addr, rom_en, kw_out, kw_f, kw_valid, kw_last,
        output kw_in, kw_ready
    );
endinterface

// File: rtl/kw_fetch_sequencer.sv
// kw_fetch_sequencer
//   Walks all 8 filters x WORDS_PER_F ROM words. For each word it issues one
//   ROM read, waits ROM_LAT cycles, captures the multiplexed word, and then
//   offers the word to the PE array over a valid/ready handshake. After the
//   last word is accepted, done pulses for one cycle.
//   Ports:
//     clk, rst : clock and asynchronous active-high reset.
//     start    : one-cycle request to begin a run. It is ignored unless the
//                sequencer is idle.
//     abort    : synchronous cancel. The sequencer returns to idle on the
//                next cycle.
//     busy     : high whenever the sequencer is not idle.
//     done     : one-cycle pulse after the final word is accepted.
//     bus      : ROM address/enable, mux select F and kw_* handshake.
module kw_fetch_sequencer #(
    parameter int unsigned WORD_W      = 384,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WORDS_PER_F = 4,
    parameter int unsigned ROM_LAT     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    kw_fetch_sequencer_if.master bus
);
    localparam int unsigned       CNT_W     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_F - 1);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        f_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  wait_q;
    logic [WORD_W-1:0] kw_out_q;
    logic [2:0]        kw_f_q;
    logic              kw_last_q;
    logic              kill;
    logic              accept;

    // abort only matters outside IDLE. In IDLE, it simply masks start.
    assign kill   = abort && (state_q != S_IDLE);
    assign accept = (state_q == S_HOLD) && bus.kw_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && !abort) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_q == '0) state_d = S_HOLD;
            S_HOLD:  if (accept) state_d = kw_last_q ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            kw_out_q  <= '0;
            kw_f_q    <= '0;
            kw_last_q <= '0;
        end else if (kill) begin
            f_q       <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            kw_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        f_q    <= '0;
                        addr_q <= '0;
                    end
                end
                S_ISSUE: wait_q <= WAIT_INIT;
                S_WAIT: begin
                    if (wait_q == '0) begin
                        kw_out_q  <= bus.kw_in;
                        kw_f_q    <= f_q;
                        kw_last_q <= (f_q == 3'd7) && (addr_q == LAST_ADDR);
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        // kw_last only qualifies a word while it is being offered.
                        kw_last_q <= 1'b0;
                        if (kw_last_q) begin
                            f_q    <= '0;
                            addr_q <= '0;
                        end else if (addr_q == LAST_ADDR) begin
                            addr_q <= '0;
                            f_q    <= f_q + 3'd1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    f_q    <= '0;
                    addr_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.F        = f_q;
    assign bus.rom_addr = addr_q;
    assign bus.rom_en   = (state_q == S_ISSUE);
    assign bus.kw_out   = kw_out_q;
    assign bus.kw_f     = kw_f_q;
    assign bus.kw_valid = (state_q == S_HOLD);
    assign bus.kw_last  = kw_last_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
endmodule

// File: tb/tb_kw_fetch_sequencer.sv
// tb_kw_fetch_sequencer
//   Directed bench for kw_fetch_sequencer. It uses two instances:
//     u0 : defaults (ROM_LAT=1, WORDS_PER_F=4).
//     u1 : ROM_LAT=3, WORDS_PER_F=1.
//   Each ROM model returns a {F, addr} byte pattern ROM_LAT cycles after
//   rom_en. On every other cycle it returns all ones.
module tb_kw_fetch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic start0 = 1'b0, abort0 = 1'b0, busy0, done0;
    logic start1 = 1'b0, abort1 = 1'b0, busy1, done1;

    kw_fetch_sequencer_if #(.WORD_W(384), .ADDR_W(6)) bus0 ();
    kw_fetch_sequencer_if #(.WORD_W(384), .ADDR_W(6)) bus1 ();

    kw_fetch_sequencer #(.WORD_W(384), .ADDR_W(6), .WORDS_PER_F(4), .ROM_LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .bus(bus0)
    );

    kw_fetch_sequencer #(.WORD_W(384), .ADDR_W(6), .WORDS_PER_F(1), .ROM_LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .bus(bus1)
    );

    function automatic logic [383:0] mk(input int unsigned f, input int unsigned a);
        logic [7:0] b;
        b = {f[2:0], a[4:0]};
        return {48{b}};
    endfunction

    logic [383:0] rom0_q;
    logic [383:0] rom1_q [3];

    always @(posedge clk) begin
        rom0_q    <= bus0.rom_en ? mk(bus0.F, bus0.rom_addr) : '1;
        rom1_q[0] <= bus1.rom_en ? mk(bus1.F, bus1.rom_addr) : '1;
        rom1_q[1] <= rom1_q[0];
        rom1_q[2] <= rom1_q[1];
    end

    assign bus0.kw_in = rom0_q;
    assign bus1.kw_in = rom1_q[2];

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_F"}, bus0.F, 0);
        check({tag, "_addr"}, bus0.rom_addr, 0);
        check({tag, "_en"}, bus0.rom_en, 0);
        check({tag, "_out"}, bus0.kw_out, 0);
        check({tag, "_kwf"}, bus0.kw_f, 0);
        check({tag, "_valid"}, bus0.kw_valid, 0);
        check({tag, "_last"}, bus0.kw_last, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
    endtask

    // Starts u0 and sequences the handshakes. It returns at the negedge where
    // stop_n words have been accepted, or after done completes if stop_n >= 32.
    task automatic run0(input int unsigned pct, input int unsigned stop_n, input bit noise);
        int unsigned n = 0;
        int unsigned roms = 0;
        int unsigned cyc = 0;
        bit stalled = 1'b0;
        logic [383:0] prev_w = '0;
        logic [2:0] prev_f = '0;
        logic prev_l = 1'b0;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            start0 = noise && (cyc == 10);
            if (stalled) begin
                check("stall_valid", bus0.kw_valid, 1);
                check("stall_out", bus0.kw_out, prev_w);
                check("stall_kwf", bus0.kw_f, prev_f);
                check("stall_last", bus0.kw_last, prev_l);
            end
            if (bus0.rom_en) roms++;
            if (done0) begin
                check("n_words", n, 32);
                check("rom_en_cnt", roms, 32);
                check("busy_in_done", busy0, 1);
                if (pct == 100) check("done_cyc", cyc, 97);
                @(negedge clk);
                check("post_done", done0, 0);
                check("post_busy", busy0, 0);
                check("post_F", bus0.F, 0);
                check("post_addr", bus0.rom_addr, 0);
                return;
            end
            if (n == stop_n) begin
                bus0.kw_ready = 1'b0;
                start0 = 1'b0;
                return;
            end
            bus0.kw_ready = ($urandom_range(99) < pct);
            stalled = bus0.kw_valid && !bus0.kw_ready;
            prev_w = bus0.kw_out;
            prev_f = bus0.kw_f;
            prev_l = bus0.kw_last;
            if (bus0.kw_valid && bus0.kw_ready) begin
                check("word", bus0.kw_out, mk(n / 4, n % 4));
                check("kw_f", bus0.kw_f, n / 4);
                check("kw_last", bus0.kw_last, n == 31);
                if (pct == 100) check("word_cyc", cyc, 3 * (n + 1));
                n++;
            end
        end
        check("timeout0", done0, 1);
    endtask

    task automatic run1();
        int unsigned n = 0;
        int unsigned roms = 0;
        int unsigned cyc = 0;
        bus1.kw_ready = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (bus1.rom_en) roms++;
            if (done1) begin
                check("u1_n_words", n, 8);
                check("u1_rom_en_cnt", roms, 8);
                check("u1_done_cyc", cyc, 41);
                return;
            end
            check("u1_F_stable", bus1.F, n);
            check("u1_addr_stable", bus1.rom_addr, 0);
            if (bus1.kw_valid) begin
                check("u1_word", bus1.kw_out, mk(n, 0));
                check("u1_kw_f", bus1.kw_f, n);
                check("u1_last", bus1.kw_last, n == 7);
                check("u1_word_cyc", cyc, 5 * (n + 1));
                n++;
            end
        end
        check("timeout1", done1, 1);
    endtask

    initial begin
        bit seen_done;
        bit seen_valid;
        bus0.kw_ready = 1'b0;
        bus1.kw_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero0("rst");
        rst = 1'b0;
        @(negedge clk);

        // Reset while word 5 (F1a0) is waiting on the ROM.
        run0(100, 4, 1'b0);
        check("issue5_en", bus0.rom_en, 1);
        @(negedge clk);
        check("wait5_en", bus0.rom_en, 0);
        check("wait5_busy", busy0, 1);
        check("wait5_F", bus0.F, 1);
        rst = 1'b1;
        #1;
        check_zero0("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full run with a start pulse injected while busy.
        run0(100, 99, 1'b1);
        // Back-pressure.
        run0(30, 99, 1'b0);

        // start and abort together while idle.
        start0 = 1'b1;
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        @(negedge clk);
        check("sa_busy", busy0, 0);
        check("sa_en", bus0.rom_en, 0);

        // Abort in HOLD of F3a2, with a same-cycle handshake.
        run0(100, 14, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ab_valid", bus0.kw_valid, 1);
        check("ab_kwf", bus0.kw_f, 3);
        check("ab_word", bus0.kw_out, mk(3, 2));
        @(negedge clk);
        check("ab_stall_word", bus0.kw_out, mk(3, 2));
        abort0 = 1'b1;
        bus0.kw_ready = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        bus0.kw_ready = 1'b0;
        check("ab_busy", busy0, 0);
        check("ab_valid0", bus0.kw_valid, 0);
        check("ab_last0", bus0.kw_last, 0);
        check("ab_en0", bus0.rom_en, 0);
        check("ab_F0", bus0.F, 0);
        check("ab_addr0", bus0.rom_addr, 0);
        check("ab_done0", done0, 0);
        seen_done = 1'b0;
        seen_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen_done = seen_done | done0;
            seen_valid = seen_valid | bus0.kw_valid;
        end
        check("ab_no_done", seen_done, 0);
        check("ab_no_word", seen_valid, 0);
        run0(100, 99, 1'b0);

        // ROM_LAT=3, WORDS_PER_F=1 instance.
        run1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kw_fetch_sequencer.md
# kw_fetch_sequencer

Sequencer directly upstream of the kernel-weight select multiplexer: it drives the 3-bit filter index F and the shared ROM address/enable, waits out the ROM read latency, captures the 384-bit word returned through the multiplexer, and delivers it to the convolution PE array over a valid/ready handshake. One start pulse walks all 8 filters × WORDS_PER_F words in order, then pulses done.

## Interface
- WORD_W, 384, kernel weight word width; equals the multiplexer output width.
- ADDR_W, 6, ROM address width.
- WORDS_PER_F, 4, words per filter kernel; range 1..2^ADDR_W.
- ROM_LAT, 1, ROM read latency in cycles, ≥1.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a full fetch; ignored unless IDLE.
- abort  in  1  synchronous cancel; return to IDLE next cycle.
- F  out  3  filter index to the select multiplexer.
- rom_addr  out  ADDR_W  word address broadcast to all 8 ROMs.
- rom_en  out  1  ROM read enable, high in ISSUE only.
- kw_in  in  WORD_W  selected weight word from the multiplexer.
- kw_out  out  WORD_W  captured weight word to the PE array.
- kw_f  out  3  filter tag of kw_out.
- kw_valid  out  1  kw_out/kw_f/kw_last valid.
- kw_ready  in  1  PE array accepts the word.
- kw_last  out  1  high with kw_valid on the final word (F=7, addr=WORDS_PER_F-1).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after final word accepted.

## Operation
- Reset value of every output: 0 (F, rom_addr, rom_en, kw_out, kw_f, kw_valid, kw_last, busy, done). State IDLE; wait counter 0.
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE: start=1 → load F=0, rom_addr=0, go ISSUE.
- ISSUE: rom_en=1 for exactly one cycle; → WAIT with wait counter = ROM_LAT-1.
- WAIT: rom_en=0; F and rom_addr held stable (the multiplexer is combinational on F). When counter = 0, register kw_in into kw_out, kw_f←F, kw_last←(F=7 && rom_addr=WORDS_PER_F-1), go HOLD; else decrement.
- HOLD: kw_valid=1; kw_out, kw_f, kw_last stable until handshake. On kw_valid && kw_ready: if kw_last → DONE; else if rom_addr=WORDS_PER_F-1 → rom_addr=0, F=F+1, ISSUE; else rom_addr+1, ISSUE. kw_valid drops the cycle after handshake.
- DONE: done=1 one cycle; F and rom_addr return to 0; → IDLE.
- Counter arithmetic: rom_addr compares against WORDS_PER_F-1, never wraps past it; F increments only at a filter boundary, never wraps beyond 7 (transition to DONE instead).
- abort (any non-IDLE state, priority over all other transitions): next cycle IDLE, kw_valid=0, kw_last=0, rom_en=0, F=0, rom_addr=0, no done pulse. A handshake in the same cycle as abort counts as accepted but is not followed by any further word.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- rst asserted mid-operation: all outputs to reset values immediately, no done pulse.

## Timing
- Start sampled at edge E0 → ISSUE in cycle after E0; rom_en high that cycle.
- First kw_valid: ROM_LAT+2 cycles after the start edge (ROM_LAT=1: 3 cycles).
- With kw_ready held high, one word per ROM_LAT+2 cycles (ROM_LAT=1: 3); no prefetch overlap.
- Full run with kw_ready=1: 8·WORDS_PER_F·(ROM_LAT+2)+1 cycles from start edge to done cycle (defaults: 97); busy high throughout, including the done cycle.
- kw_ready low in HOLD stalls indefinitely; no output changes during stall.

## Test plan
- Reset: assert rst mid-WAIT of word 5 → all outputs 0 same cycle; after release, start runs a complete clean sequence.
- Full run, defaults, kw_ready=1, ROM word = {F, addr} pattern → 32 words in order F0a0..F7a3, kw_f matches, kw_last only on F7a3, done at cycle 97, exactly one rom_en per word.
- Back-pressure: kw_ready random 30% high → same 32-word order, no drops/duplicates, kw_out stable while kw_valid && !kw_ready.
- Abort in HOLD of F3a2 with kw_ready=0 → IDLE next cycle, kw_valid=0, no done; new start restarts at F0a0.
- start pulsed while busy and start+abort in IDLE → both ignored, sequence/idle unaffected.
- ROM_LAT=3, WORDS_PER_F=1 → 8 words, 5 cycles each, F/rom_addr stable throughout each WAIT, done at cycle 41.
